// File: rtl/pid_ctrl_pkg.sv
// Shared types for the PID motor controller: operating modes, FSM states, multiplier selects.
// PID_LAT is the fixed trigger-to-output latency in clock cycles.
package pid_ctrl_pkg;

   typedef enum logic [1:0] {
      MODE_OFF  = 2'd0,
      MODE_BIAS = 2'd1,
      MODE_CALI = 2'd2,
      MODE_PID  = 2'd3
   } mode_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ERR  = 3'd1,
      ST_MP   = 3'd2,
      ST_MI   = 3'd3,
      ST_MD   = 3'd4,
      ST_ACC  = 3'd5,
      ST_SUM  = 3'd6,
      ST_SAT  = 3'd7
   } state_e;

   typedef enum logic [1:0] {
      MAC_P = 2'd0,
      MAC_I = 2'd1,
      MAC_D = 2'd2
   } mac_sel_e;

   localparam int PID_LAT = 8;

endpackage

// File: rtl/pid_ctrl_gen_mac.sv
// Shared signed(error) x unsigned(gain) multiplier with operand mux; one cycle registered,
// result sign-extended to ACC_W. No backpressure: a new product every cycle.
module pid_mac_unit
   import pid_ctrl_pkg::*;
#(
   parameter int POS_W  = 25,
   parameter int COEF_W = 23,
   parameter int ACC_W  = 56
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [1:0]              sel,
   input  logic [COEF_W-1:0]       kp,
   input  logic [COEF_W-1:0]       ki,
   input  logic [COEF_W-1:0]       kd,
   input  logic signed [POS_W:0]   err,
   input  logic signed [POS_W+1:0] derr,
   output logic signed [ACC_W-1:0] prod
);

   localparam int PW = POS_W + COEF_W + 3;

   logic signed [POS_W+1:0] a;
   logic [COEF_W-1:0]       b;
   logic signed [PW-1:0]    a_x;
   logic signed [PW-1:0]    b_x;
   logic signed [PW-1:0]    p_full;

   always_comb begin
      a = {err[POS_W], err};
      b = kp;
      case (sel)
         MAC_I: b = ki;
         MAC_D: begin
            a = derr;
            b = kd;
         end
         default: b = kp;
      endcase
   end

   // Both operands widened to the exact product width so the multiply never truncates.
   assign a_x    = {{(PW-POS_W-2){a[POS_W+1]}}, a};
   assign b_x    = {{(PW-COEF_W){1'b0}}, b};
   assign p_full = a_x * b_x;

   always_ff @(posedge clk) begin
      if (rst) begin
         prod <= '0;
      end else begin
         prod <= {{(ACC_W-PW){p_full[PW-1]}}, p_full};
      end
   end

endmodule

// File: rtl/pid_ctrl_gen.sv
// Periodic P/I/D position controller with feed-forward, bias, calibration and DAC saturation.
// Output strobe exactly 8 cycles after each accepted trigger; triggers arriving while busy are dropped.
module pid_ctrl_gen
   import pid_ctrl_pkg::*;
#(
   parameter int POS_W  = 25,
   parameter int COEF_W = 23,
   parameter int OUT_W  = 16,
   parameter int ACC_W  = 56,
   parameter int FRAC_W = 24
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [1:0]        mode_i,
   input  logic [31:0]       period_i,
   input  logic [COEF_W-1:0] kp_i,
   input  logic [COEF_W-1:0] ki_i,
   input  logic [COEF_W-1:0] kd_i,
   input  logic [ACC_W-2:0]  int_limit_i,
   input  logic [POS_W-1:0]  position_aim_i,
   input  logic              position_en_i,
   input  logic [POS_W-1:0]  position_i,
   input  logic              ufeed_en_i,
   input  logic [OUT_W-1:0]  ufeed_i,
   input  logic [OUT_W-1:0]  bias_i,
   input  logic [OUT_W-1:0]  cali_set_i,
   output logic              trigger_o,
   output logic              out_vld_o,
   output logic [OUT_W-1:0]  out_data_o,
   output logic [OUT_W-1:0]  ufeed_latch_o,
   output logic [1:0]        sat_o,
   output logic              skip_o,
   output logic              overrun_o
);

   state_e state;
   state_e state_nx;
   mode_e  mode_q;

   logic [31:0] cnt;
   logic [31:0] per_q;
   logic [31:0] per_use;
   logic        off;
   logic        wrap;
   logic        busy;
   logic        fresh;
   logic        fresh_now;
   logic        skip_now;
   logic        start;

   logic [POS_W-1:0]        pos_q;
   logic signed [POS_W:0]   e_q;
   logic signed [POS_W:0]   e_prev;
   logic signed [POS_W+1:0] de;

   mac_sel_e               mac_sel;
   logic signed [ACC_W-1:0] prod;
   logic signed [ACC_W-1:0] p_q;
   logic signed [ACC_W-1:0] i_q;
   logic signed [ACC_W-1:0] d_q;
   logic signed [ACC_W-1:0] integ;
   logic signed [ACC_W-1:0] integ_sum;
   logic signed [ACC_W-1:0] integ_nx;
   logic signed [ACC_W-1:0] lim;
   logic signed [ACC_W-1:0] pid_sum;
   logic signed [ACC_W-1:0] pid_sh;
   logic signed [ACC_W-1:0] uf_x;
   logic signed [ACC_W-1:0] bias_x;
   logic signed [ACC_W-1:0] s_sum;
   logic signed [ACC_W-1:0] s_q;
   logic                    hold;

   assign off       = (mode_i == MODE_OFF) || (period_i == 32'd0);
   assign per_use   = (per_q == 32'd0) ? period_i : per_q;
   assign wrap      = (cnt >= per_use - 32'd1);
   assign busy      = (state != ST_IDLE);
   assign fresh_now = fresh | position_en_i;
   assign skip_now  = trigger_o & ~busy & ~off & (mode_i == MODE_PID) & ~fresh_now;
   assign start     = trigger_o & ~busy & ~off & ~skip_now;

   // Trigger generator; the period is re-sampled only at a wrap or while disabled.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt       <= '0;
         per_q     <= '0;
         trigger_o <= 1'b0;
      end else if (off) begin
         cnt       <= '0;
         per_q     <= period_i;
         trigger_o <= 1'b0;
      end else if (wrap) begin
         cnt       <= '0;
         per_q     <= period_i;
         trigger_o <= 1'b1;
      end else begin
         cnt       <= cnt + 32'd1;
         trigger_o <= 1'b0;
      end
   end

   // A sample arriving in the trigger cycle is captured and consumed by that trigger.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pos_q  <= '0;
         fresh  <= 1'b0;
         mode_q <= MODE_OFF;
      end else begin
         if (position_en_i) begin
            pos_q <= position_i;
         end
         if (start) begin
            fresh  <= 1'b0;
            mode_q <= mode_e'(mode_i);
         end else if (position_en_i) begin
            fresh <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      mac_sel  = MAC_P;
      case (state)
         ST_IDLE: if (start) state_nx = ST_ERR;
         ST_ERR:  state_nx = ST_MP;
         ST_MP: begin
            mac_sel  = MAC_P;
            state_nx = ST_MI;
         end
         ST_MI: begin
            mac_sel  = MAC_I;
            state_nx = ST_MD;
         end
         ST_MD: begin
            mac_sel  = MAC_D;
            state_nx = ST_ACC;
         end
         ST_ACC:  state_nx = ST_SUM;
         ST_SUM:  state_nx = ST_SAT;
         ST_SAT:  state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
      if (off) begin
         state_nx = ST_IDLE;
      end
   end

   pid_mac_unit #(
      .POS_W  (POS_W),
      .COEF_W (COEF_W),
      .ACC_W  (ACC_W)
   ) u_mac (
      .clk  (clk_i),
      .rst  (rst_i),
      .sel  (mac_sel),
      .kp   (kp_i),
      .ki   (ki_i),
      .kd   (kd_i),
      .err  (e_q),
      .derr (de),
      .prod (prod)
   );

   assign de        = {e_q[POS_W], e_q} - {e_prev[POS_W], e_prev};
   assign lim       = $signed({1'b0, int_limit_i});
   assign integ_sum = integ + i_q;

   // Anti-windup: do not push further into the rail the previous output already hit.
   assign hold = (sat_o[1] && !e_q[POS_W] && (e_q != '0)) ||
                 (sat_o[0] &&  e_q[POS_W]);

   always_comb begin
      integ_nx = integ_sum;
      if (hold) begin
         integ_nx = integ;
      end else if (integ_sum > lim) begin
         integ_nx = lim;
      end else if (integ_sum < -lim) begin
         integ_nx = -lim;
      end
   end

   // Shift kept in its own signed term so the unsigned codes cannot turn it logical.
   assign pid_sum = p_q + integ + d_q;
   assign pid_sh  = pid_sum >>> FRAC_W;
   assign uf_x    = $signed({{(ACC_W-OUT_W){1'b0}}, ufeed_latch_o});
   assign bias_x  = $signed({{(ACC_W-OUT_W){1'b0}}, bias_i});
   assign s_sum   = pid_sh + uf_x + bias_x;

   // Products come out of the MAC one state after their operands were presented.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         e_q    <= '0;
         e_prev <= '0;
         p_q    <= '0;
         i_q    <= '0;
         d_q    <= '0;
         integ  <= '0;
         s_q    <= '0;
      end else if (off) begin
         integ  <= '0;
         e_prev <= '0;
      end else begin
         case (state)
            ST_ERR: e_q <= {position_aim_i[POS_W-1], position_aim_i} -
                           {pos_q[POS_W-1], pos_q};
            ST_MI:  p_q <= prod;
            ST_MD:  i_q <= prod;
            ST_ACC: begin
               d_q <= prod;
               if (mode_q == MODE_PID) begin
                  integ  <= integ_nx;
                  e_prev <= e_q;
               end
            end
            ST_SUM: s_q <= s_sum;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_vld_o     <= 1'b0;
         out_data_o    <= '0;
         sat_o         <= 2'b00;
         skip_o        <= 1'b0;
         overrun_o     <= 1'b0;
         ufeed_latch_o <= '0;
      end else begin
         out_vld_o <= 1'b0;
         skip_o    <= skip_now;
         overrun_o <= trigger_o & busy & ~off;
         if (ufeed_en_i) begin
            ufeed_latch_o <= ufeed_i;
         end
         if ((state == ST_SAT) && !off) begin
            out_vld_o <= 1'b1;
            case (mode_q)
               MODE_BIAS: begin
                  out_data_o <= bias_i;
                  sat_o      <= 2'b00;
               end
               MODE_CALI: begin
                  out_data_o <= cali_set_i;
                  sat_o      <= 2'b00;
               end
               default: begin
                  if (s_q[ACC_W-1]) begin
                     out_data_o <= '0;
                     sat_o      <= 2'b01;
                  end else if (|s_q[ACC_W-1:OUT_W]) begin
                     out_data_o <= '1;
                     sat_o      <= 2'b10;
                  end else begin
                     out_data_o <= s_q[OUT_W-1:0];
                     sat_o      <= 2'b00;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pid_ctrl_gen.sv
// Directed table-driven bench for pid_ctrl_gen plus hand-written sequences for abort, overrun and reset.
module tb_pid_ctrl_gen;

   // A gain of exactly 1.0 needs FRAC_W+1 coefficient bits.
   localparam int POS_W  = 25;
   localparam int COEF_W = 25;
   localparam int OUT_W  = 16;
   localparam int ACC_W  = 56;
   localparam int FRAC_W = 24;
   localparam int ONE    = 1 << 24;
   localparam longint BIG = 64'd1 << 50;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic [1:0]        mode_i;
   logic [31:0]       period_i;
   logic [COEF_W-1:0] kp_i, ki_i, kd_i;
   logic [ACC_W-2:0]  int_limit_i;
   logic [POS_W-1:0]  position_aim_i;
   logic              position_en_i;
   logic [POS_W-1:0]  position_i;
   logic              ufeed_en_i;
   logic [OUT_W-1:0]  ufeed_i, bias_i, cali_set_i;
   logic              trigger_o, out_vld_o, skip_o, overrun_o;
   logic [OUT_W-1:0]  out_data_o, ufeed_latch_o;
   logic [1:0]        sat_o;

   int checks = 0;
   int errors = 0;

   pid_ctrl_gen #(
      .POS_W(POS_W), .COEF_W(COEF_W), .OUT_W(OUT_W), .ACC_W(ACC_W), .FRAC_W(FRAC_W)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .mode_i(mode_i), .period_i(period_i),
      .kp_i(kp_i), .ki_i(ki_i), .kd_i(kd_i), .int_limit_i(int_limit_i),
      .position_aim_i(position_aim_i), .position_en_i(position_en_i), .position_i(position_i),
      .ufeed_en_i(ufeed_en_i), .ufeed_i(ufeed_i), .bias_i(bias_i), .cali_set_i(cali_set_i),
      .trigger_o(trigger_o), .out_vld_o(out_vld_o), .out_data_o(out_data_o),
      .ufeed_latch_o(ufeed_latch_o), .sat_o(sat_o), .skip_o(skip_o), .overrun_o(overrun_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [1:0] mode;
      logic       clr;
      logic       smp;
      int         kp, ki, kd;
      longint     lim;
      int         aim, pos;
      int         bias, ufeed, cali;
      logic       vld;
      int         data;
      logic [1:0] sat;
      logic       skip;
   } vec_t;

   vec_t vt[16];

   function automatic vec_t mk(input logic [1:0] m, input logic c, input logic s,
                               input int kp, input int ki, input int kd, input longint lim,
                               input int aim, input int pos, input int bias, input int uf,
                               input int cali, input logic vld, input int data,
                               input logic [1:0] sat, input logic skip);
      vec_t v;
      v.mode = m; v.clr = c; v.smp = s; v.kp = kp; v.ki = ki; v.kd = kd; v.lim = lim;
      v.aim = aim; v.pos = pos; v.bias = bias; v.ufeed = uf; v.cali = cali;
      v.vld = vld; v.data = data; v.sat = sat; v.skip = skip;
      return v;
   endfunction

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual %0d required %0d", nm, act, exp);
      end
   endtask

   task automatic wait_trig(input string nm, output logic found);
      found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
         @(negedge clk_i);
         if (trigger_o) found = 1'b1;
      end
      chk({nm, "_trigger_seen"}, found, 1);
   endtask

   // Called in the trigger cycle; walks to trigger+8 and checks the result.
   task automatic check_after(input string nm, input logic ev, input int ed,
                              input logic [1:0] es, input logic esk, input int euf);
      logic early;
      early = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk_i);
         position_en_i = 1'b0;
         if (k == 1) chk({nm, "_skip"}, skip_o, esk);
         if (k < 8 && out_vld_o) early = 1'b1;
      end
      chk({nm, "_early_vld"}, early, 0);
      chk({nm, "_vld"}, out_vld_o, ev);
      if (ev) begin
         chk({nm, "_data"}, out_data_o, ed);
         chk({nm, "_sat"}, sat_o, es);
      end
      chk({nm, "_ufeed"}, ufeed_latch_o, euf);
   endtask

   task automatic apply(input vec_t v);
      if (v.clr) begin
         mode_i = 2'd0;
         repeat (3) @(negedge clk_i);
      end
      mode_i         = v.mode;
      kp_i           = COEF_W'(v.kp);
      ki_i           = COEF_W'(v.ki);
      kd_i           = COEF_W'(v.kd);
      int_limit_i    = (ACC_W-1)'(v.lim);
      position_aim_i = POS_W'(v.aim);
      bias_i         = OUT_W'(v.bias);
      cali_set_i     = OUT_W'(v.cali);
      ufeed_i        = OUT_W'(v.ufeed);
      ufeed_en_i     = 1'b1;
      if (v.smp) begin
         position_i    = POS_W'(v.pos);
         position_en_i = 1'b1;
      end
      @(negedge clk_i);
      ufeed_en_i    = 1'b0;
      position_en_i = 1'b0;
   endtask

   initial begin
      logic found;
      int   nv;
      logic vld_log[1:20];
      logic ovr_log[1:20];
      logic trg_log[1:20];

      rst_i = 1'b1; mode_i = 2'd0; period_i = 32'd100;
      kp_i = '0; ki_i = '0; kd_i = '0; int_limit_i = (ACC_W-1)'(BIG);
      position_aim_i = '0; position_en_i = 1'b0; position_i = '0;
      ufeed_en_i = 1'b0; ufeed_i = '0; bias_i = '0; cali_set_i = '0;

      vt[0]  = mk(3, 1, 1, ONE, 0, 0, BIG, 100, 40, 1000, 0, 0, 1, 1060, 2'b00, 0);
      vt[1]  = mk(3, 0, 1, ONE, 0, 0, BIG, 100, 40, 1000, 200, 0, 1, 1260, 2'b00, 0);
      vt[2]  = mk(3, 1, 1, ONE, 0, 0, BIG, 0, 5000, 1000, 0, 0, 1, 0, 2'b01, 0);
      vt[3]  = mk(3, 0, 1, 0, ONE, 0, BIG, 0, 5000, 1000, 0, 0, 1, 1000, 2'b00, 0);
      vt[4]  = mk(3, 0, 1, 0, ONE, 0, BIG, 0, 5000, 1000, 0, 0, 1, 0, 2'b01, 0);
      vt[5]  = mk(3, 1, 1, 0, ONE, 0, 25*ONE, 10, 0, 0, 0, 0, 1, 10, 2'b00, 0);
      vt[6]  = mk(3, 0, 1, 0, ONE, 0, 25*ONE, 10, 0, 0, 0, 0, 1, 20, 2'b00, 0);
      vt[7]  = mk(3, 0, 1, 0, ONE, 0, 25*ONE, 10, 0, 0, 0, 0, 1, 25, 2'b00, 0);
      vt[8]  = mk(3, 0, 1, 0, ONE, 0, 25*ONE, 10, 0, 0, 0, 0, 1, 25, 2'b00, 0);
      vt[9]  = mk(3, 1, 1, 0, 0, ONE, BIG, 10, 0, 0, 0, 0, 1, 10, 2'b00, 0);
      vt[10] = mk(3, 0, 1, 0, 0, ONE, BIG, 30, 0, 0, 0, 0, 1, 20, 2'b00, 0);
      vt[11] = mk(2, 0, 0, 0, 0, 0, BIG, 0, 0, 0, 0, 'h1234, 1, 'h1234, 2'b00, 0);
      vt[12] = mk(1, 0, 0, 0, 0, 0, BIG, 0, 0, 'h0800, 0, 0, 1, 'h0800, 2'b00, 0);
      vt[13] = mk(3, 0, 0, ONE, 0, 0, BIG, 50, 0, 0, 0, 0, 0, 0, 2'b00, 1);
      vt[14] = mk(3, 1, 1, ONE, 0, 0, BIG, 60, 0, 'hFFF0, 0, 0, 1, 'hFFFF, 2'b10, 0);
      vt[15] = mk(3, 0, 1, 0, ONE, 0, BIG, 60, 0, 'hFFF0, 0, 0, 1, 'hFFF0, 2'b00, 0);
      nv = 16;

      repeat (3) @(negedge clk_i);
      chk("reset_outputs", {trigger_o, out_vld_o, out_data_o, ufeed_latch_o, sat_o, skip_o, overrun_o}, 0);
      rst_i = 1'b0;
      @(negedge clk_i);

      for (int i = 0; i < nv; i++) begin
         apply(vt[i]);
         wait_trig($sformatf("v%0d", i), found);
         if (found)
            check_after($sformatf("v%0d", i), vt[i].vld, vt[i].data, vt[i].sat, vt[i].skip, vt[i].ufeed);
      end

      // Sample strobed in the trigger cycle replaces the older pending one.
      apply(mk(3, 0, 1, ONE, 0, 0, BIG, 100, 0, 0, 0, 0, 1, 0, 2'b00, 0));
      wait_trig("same_cycle", found);
      if (found) begin
         position_i    = POS_W'(20);
         position_en_i = 1'b1;
         check_after("same_cycle", 1, 80, 2'b00, 0, 0);
      end

      // Abort mid-calculation: no strobe, integrator cleared.
      apply(mk(3, 1, 1, 0, ONE, 0, BIG, 10, 0, 0, 0, 0, 1, 0, 2'b00, 0));
      wait_trig("abort_pre", found);
      if (found) check_after("abort_pre", 1, 10, 2'b00, 0, 0);
      apply(mk(3, 0, 1, 0, ONE, 0, BIG, 10, 0, 0, 0, 0, 1, 0, 2'b00, 0));
      wait_trig("abort", found);
      if (found) begin
         int vcnt;
         vcnt = 0;
         repeat (3) @(negedge clk_i);
         mode_i = 2'd0;
         for (int k = 0; k < 10; k++) begin
            @(negedge clk_i);
            if (out_vld_o) vcnt++;
         end
         chk("abort_no_vld", vcnt, 0);
      end
      apply(mk(3, 0, 1, 0, ONE, 0, BIG, 10, 0, 0, 0, 0, 1, 0, 2'b00, 0));
      wait_trig("abort_post", found);
      if (found) check_after("abort_post", 1, 10, 2'b00, 0, 0);

      // Period 5: every second trigger lands on a busy FSM.
      mode_i = 2'd0;
      repeat (3) @(negedge clk_i);
      period_i = 32'd5;
      bias_i   = OUT_W'('h55);
      mode_i   = 2'd1;
      wait_trig("ovr", found);
      if (found) begin
         int vcnt;
         vcnt = 0;
         for (int k = 1; k <= 20; k++) begin
            @(negedge clk_i);
            vld_log[k] = out_vld_o;
            ovr_log[k] = overrun_o;
            trg_log[k] = trigger_o;
            if (out_vld_o) vcnt++;
         end
         chk("ovr_trig5", trg_log[5], 1);
         chk("ovr_pulse6", ovr_log[6], 1);
         chk("ovr_vld8", vld_log[8], 1);
         chk("ovr_data", out_data_o, 'h55);
         chk("ovr_vld13", vld_log[13], 0);
         chk("ovr_none11", ovr_log[11], 0);
         chk("ovr_vld18", vld_log[18], 1);
         chk("ovr_vld_count", vcnt, 2);
      end
      mode_i   = 2'd0;
      period_i = 32'd100;
      repeat (2) @(negedge clk_i);

      // Reset in the middle of a calculation.
      apply(mk(3, 0, 1, ONE, 0, 0, BIG, 100, 0, 300, 7, 0, 1, 0, 2'b00, 0));
      wait_trig("rst_mid", found);
      if (found) begin
         int vcnt;
         vcnt = 0;
         repeat (2) @(negedge clk_i);
         rst_i = 1'b1;
         repeat (2) @(negedge clk_i);
         chk("rst_mid_outputs", {trigger_o, out_vld_o, out_data_o, ufeed_latch_o, sat_o, skip_o, overrun_o}, 0);
         rst_i = 1'b0;
         for (int k = 0; k < 12; k++) begin
            @(negedge clk_i);
            if (out_vld_o) vcnt++;
         end
         chk("rst_mid_no_vld", vcnt, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
